clint_irq_source: RTL and testbench
===================================

// Module: clint_irq_source
// PURPOSE
//  Machine-level interrupt source (CLINT-style) feeding the core's trap logic.
//  Holds mtime/mtimecmp/msip as memory-mapped registers on the data bus and
//  synchronises one external interrupt line. Raises a level interrupt request
//  with its mcause code; the trap unit acknowledges entry (trap_taken) and
//  return (mret_done). Sits beside data memory on the MEM-stage bus.
// PARAMETERS
//  PRESCALE   100   clk cycles per mtime tick (>=1; 1 = tick every cycle)
//  SYNC_STAGES 2    flops on ext_irq_async (>=2)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, asynchronous, active-high
//  bus_req       in   1   access request (one-cycle pulse or held)
//  bus_we        in   1   1 = write, 0 = read
//  bus_addr      in   16  byte offset, word aligned
//  bus_wdata     in   32  write data
//  bus_rdata     out  32  read data, valid when bus_ready
//  bus_ready     out  1   one-cycle completion pulse
//  bus_err       out  1   with bus_ready: unmapped/misaligned offset
//  ext_irq_async in   1   external interrupt, asynchronous level
//  mie_bits      in   3   {MEIE,MTIE,MSIE} from mie CSR
//  mstatus_mie   in   1   global machine interrupt enable
//  trap_taken    in   1   pulse: core entered trap for our request
//  mret_done     in   1   pulse: core executed mret
//  irq           out  1   interrupt request to trap unit
//  irq_cause     out  32  mcause value while irq=1, else 0
//  pend_bits     out  3   {MEIP,MTIP,MSIP} for mip CSR
// BEHAVIOUR
//  Register map (32-bit words): 0x0000 msip (bit0 only, others RAZ/WI);
//   0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0];
//   0xBFFC mtime[63:32]. Other offsets or addr[1:0]!=0: err, write ignored,
//   rdata 0.
//  Bus: request accepted the cycle bus_req=1 and no response is pending;
//   bus_ready (+rdata/err) registered, exactly 1 cycle later. Write takes
//   effect at the accepting edge. req held high -> one access per 2 cycles.
//  Prescaler: counter 0..PRESCALE-1; at terminal count mtime += 1 (64-bit,
//   wraps 2^64-1 -> 0). Bus write to mtime half same cycle as tick: write
//   wins, no increment that cycle; prescaler keeps running.
//  MTIP = (mtime >= mtimecmp), unsigned 64-bit, combinational on regs.
//  MSIP = msip[0]. MEIP = ext_irq_async after SYNC_STAGES flops.
//  Enabled set E = pend_bits & mie_bits. Priority MEI > MSI > MTI; causes
//   0x8000000B, 0x80000003, 0x80000007.
//  FSM: IDLE -> REQ when E!=0 && mstatus_mie && !in_handler.
//   REQ: irq=1, irq_cause from highest-priority bit, re-evaluated each cycle;
//   REQ -> IDLE if E becomes 0 or mstatus_mie drops (request withdrawn).
//   REQ + trap_taken -> HANDLER (irq=0 next cycle).
//   HANDLER: irq=0 regardless of pending; HANDLER + mret_done -> IDLE;
//   re-request earliest the cycle after.
//   trap_taken outside REQ ignored; mret_done outside HANDLER ignored.
//  irq and irq_cause registered (1 cycle after condition true).
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0,
//   sync flops=0, FSM=IDLE, irq=0, irq_cause=0, bus_ready=0, bus_err=0,
//   bus_rdata=0, pend_bits=0. Reset mid-access drops the response.
// TESTING
//  1 Reset -> read 0x4004 gives 0xFFFFFFFF, ready 1 cycle after req, irq=0.
//  2 PRESCALE=1, mtimecmp=5, MTIE=1, mstatus_mie=1 -> irq with cause
//    0x80000007 once mtime reaches 5; trap_taken -> irq=0 until mret_done.
//  3 Write msip=1 and raise ext_irq_async together, all enabled -> cause
//    0x8000000B; clear ext source -> cause switches to 0x80000003.
//  4 Write mtime lo=0xFFFFFFFF, hi=0 -> after one tick read hi=1, lo=0.
//  5 Read 0x0008 -> bus_err=1, rdata=0; write 0x0001 -> err, msip unchanged.
//  6 irq=1, drop mstatus_mie -> irq=0 next cycle; restore -> irq returns.

Source files
------------

// File: rtl/clint_irq_source.sv
// clint_irq_source
// Machine-level interrupt source for the core's trap logic. It holds the
// mtime, mtimecmp and msip registers on the MEM-stage data bus and
// synchronises one external interrupt line. It raises a registered level
// request with its mcause code. It then waits in a handler state until the
// core acknowledges the trap and later executes mret.
module clint_irq_source #(
    parameter int PRESCALE    = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        bus_err,
    input  logic        ext_irq_async,
    input  logic [2:0]  mie_bits,
    input  logic        mstatus_mie,
    input  logic        trap_taken,
    input  logic        mret_done,
    output logic        irq,
    output logic [31:0] irq_cause,
    output logic [2:0]  pend_bits
);

    // Register offsets inside the 64 KiB window
    localparam logic [15:0] ADDR_MSIP      = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO    = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI    = 16'h4004;
    localparam logic [15:0] ADDR_TIME_LO   = 16'hBFF8;
    localparam logic [15:0] ADDR_TIME_HI   = 16'hBFFC;

    // mcause values (interrupt bit set)
    localparam logic [31:0] CAUSE_MEI      = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI      = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI      = 32'h8000_0007;

    // Prescaler counter width; PRESCALE=1 still needs a one-bit counter
    localparam int          PW             = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST      = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HANDLER
    } state_t;

    reg_sel_t               reg_sel;
    logic                   bus_accept;
    logic                   bus_write;
    logic                   wr_msip;
    logic                   wr_cmp_lo;
    logic                   wr_cmp_hi;
    logic                   wr_time_lo;
    logic                   wr_time_hi;
    logic [31:0]            read_data;

    logic [PW-1:0]          presc_reg;
    logic                   tick;
    logic [63:0]            mtime_reg;
    logic [63:0]            mtime_next;
    logic [63:0]            mtimecmp_reg;
    logic                   msip_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    logic                   mtip;
    logic                   meip;
    logic [2:0]             enabled;
    logic [31:0]            cause_sel;

    state_t                 state_reg;
    state_t                 state_next;
    logic                   irq_reg;
    logic [31:0]            irq_cause_reg;
    logic                   bus_ready_reg;
    logic                   bus_err_reg;
    logic [31:0]            bus_rdata_reg;

    // A new access is taken only while no response is being presented, so
    // a held request alternates accept / respond cycles.
    assign bus_accept = bus_req && !bus_ready_reg;
    assign bus_write  = bus_accept && bus_we;

    // Decode the offset; any misaligned or unlisted offset selects nothing
    always_comb begin
        reg_sel = SEL_NONE;
        if (bus_addr[1:0] == 2'b00) begin
            case (bus_addr)
                ADDR_MSIP:    reg_sel = SEL_MSIP;
                ADDR_CMP_LO:  reg_sel = SEL_CMP_LO;
                ADDR_CMP_HI:  reg_sel = SEL_CMP_HI;
                ADDR_TIME_LO: reg_sel = SEL_TIME_LO;
                ADDR_TIME_HI: reg_sel = SEL_TIME_HI;
                default:      reg_sel = SEL_NONE;
            endcase
        end
    end

    assign wr_msip    = bus_write && (reg_sel == SEL_MSIP);
    assign wr_cmp_lo  = bus_write && (reg_sel == SEL_CMP_LO);
    assign wr_cmp_hi  = bus_write && (reg_sel == SEL_CMP_HI);
    assign wr_time_lo = bus_write && (reg_sel == SEL_TIME_LO);
    assign wr_time_hi = bus_write && (reg_sel == SEL_TIME_HI);

    // Read mux: unmapped offsets read as zero
    always_comb begin
        read_data = 32'h0;
        case (reg_sel)
            SEL_MSIP:    read_data = {31'h0, msip_reg};
            SEL_CMP_LO:  read_data = mtimecmp_reg[31:0];
            SEL_CMP_HI:  read_data = mtimecmp_reg[63:32];
            SEL_TIME_LO: read_data = mtime_reg[31:0];
            SEL_TIME_HI: read_data = mtime_reg[63:32];
            default:     read_data = 32'h0;
        endcase
    end

    // Bus response: one-cycle ready pulse carrying read data or error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ready_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            bus_rdata_reg <= 32'h0;
        end else begin
            bus_ready_reg <= bus_accept;
            bus_err_reg   <= bus_accept && (reg_sel == SEL_NONE);
            bus_rdata_reg <= (bus_accept && !bus_we) ? read_data : 32'h0;
        end
    end

    assign tick = (presc_reg == PS_LAST);

    // Prescaler free-runs 0..PRESCALE-1 regardless of bus traffic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    // A bus write to either half of mtime replaces that cycle's increment
    always_comb begin
        mtime_next = mtime_reg;
        if (wr_time_lo) begin
            mtime_next[31:0] = bus_wdata;
        end else if (wr_time_hi) begin
            mtime_next[63:32] = bus_wdata;
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
    end

    // mtime register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_reg <= 64'h0;
        end else begin
            mtime_reg <= mtime_next;
        end
    end

    // mtimecmp halves, written independently; reset to the maximum so the
    // timer interrupt stays quiet until software programs a deadline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_cmp_lo) begin
            mtimecmp_reg[31:0] <= bus_wdata;
        end else if (wr_cmp_hi) begin
            mtimecmp_reg[63:32] <= bus_wdata;
        end
    end

    // Software interrupt bit; upper bits of the word are not stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_reg <= 1'b0;
        end else if (wr_msip) begin
            msip_reg <= bus_wdata[0];
        end
    end

    assign sync_next = {sync_reg[SYNC_STAGES-2:0], ext_irq_async};

    // Synchroniser chain for the asynchronous external interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign meip      = sync_reg[SYNC_STAGES-1];
    assign mtip      = (mtime_reg >= mtimecmp_reg);
    assign pend_bits = {meip, mtip, msip_reg};
    assign enabled   = pend_bits & mie_bits;

    // Highest-priority enabled source: external, then software, then timer
    always_comb begin
        cause_sel = 32'h0;
        if (enabled[2]) begin
            cause_sel = CAUSE_MEI;
        end else if (enabled[0]) begin
            cause_sel = CAUSE_MSI;
        end else if (enabled[1]) begin
            cause_sel = CAUSE_MTI;
        end
    end

    // Request FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: request while enabled; an acknowledged trap parks the
    // FSM in HANDLER until mret, and a stray pulse in any other state is
    // ignored
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if ((enabled != 3'b000) && mstatus_mie) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (trap_taken) begin
                    state_next = ST_HANDLER;
                end else if ((enabled == 3'b000) || !mstatus_mie) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HANDLER: begin
                if (mret_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered request and cause, refreshed every cycle from the enabled set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_reg       <= 1'b0;
            irq_cause_reg <= 32'h0;
        end else begin
            irq_reg       <= (state_next == ST_REQ);
            irq_cause_reg <= (state_next == ST_REQ) ? cause_sel : 32'h0;
        end
    end

    assign irq       = irq_reg;
    assign irq_cause = irq_cause_reg;
    assign bus_ready = bus_ready_reg;
    assign bus_err   = bus_err_reg;
    assign bus_rdata = bus_rdata_reg;

endmodule

// File: tb/tb_clint_irq_source.sv
// Testbench for clint_irq_source: a cycle-level behavioural model checked
// against the DUT every cycle, plus directed scenarios with literal results.
module tb_clint_irq_source;

    localparam int PRESCALE    = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;
    logic        ext_irq_async;
    logic [2:0]  mie_bits;
    logic        mstatus_mie;
    logic        trap_taken;
    logic        mret_done;
    logic        irq;
    logic [31:0] irq_cause;
    logic [2:0]  pend_bits;

    int n_checks = 0;
    int n_fail   = 0;

    clint_irq_source #(
        .PRESCALE   (PRESCALE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ready    (bus_ready),
        .bus_err      (bus_err),
        .ext_irq_async(ext_irq_async),
        .mie_bits     (mie_bits),
        .mstatus_mie  (mstatus_mie),
        .trap_taken   (trap_taken),
        .mret_done    (mret_done),
        .irq          (irq),
        .irq_cause    (irq_cause),
        .pend_bits    (pend_bits)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [7:0]  m_hist;      // past samples of the external line, newest in bit 0
    int          m_cycles;    // clock edges since reset
    logic        m_irq;
    logic        m_hand;
    logic [31:0] m_cause;
    logic        m_ready;
    logic        m_err;
    logic        m_rd;
    logic [31:0] m_rdata;

    logic [2:0]  m_pend;
    logic [2:0]  m_e;
    logic        m_acc;
    logic        m_tick;
    logic        m_irq_next;
    logic        m_hand_next;

    function automatic logic m_valid(input logic [15:0] a);
        return (a == 16'h0000) || (a == 16'h4000) || (a == 16'h4004) ||
               (a == 16'hBFF8) || (a == 16'hBFFC);
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a == 16'h0000) v = {31'h0, m_msip};
        if (a == 16'h4000) v = m_cmp[31:0];
        if (a == 16'h4004) v = m_cmp[63:32];
        if (a == 16'hBFF8) v = m_mtime[31:0];
        if (a == 16'hBFFC) v = m_mtime[63:32];
        return v;
    endfunction

    function automatic logic [31:0] m_prio(input logic [2:0] e);
        if (e[2]) return 32'h8000_000B;
        if (e[0]) return 32'h8000_0003;
        if (e[1]) return 32'h8000_0007;
        return 32'h0;
    endfunction

    assign m_pend      = {m_hist[SYNC_STAGES-1], (m_mtime >= m_cmp), m_msip};
    assign m_e         = m_pend & mie_bits;
    assign m_acc       = bus_req && !m_ready;
    assign m_tick      = ((m_cycles % PRESCALE) == PRESCALE - 1);
    assign m_irq_next  = !m_hand && (m_e != 3'b000) && mstatus_mie && !(m_irq && trap_taken);
    assign m_hand_next = m_hand ? !mret_done : (m_irq && trap_taken);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mtime  <= 64'h0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip   <= 1'b0;
            m_hist   <= 8'h0;
            m_cycles <= 0;
            m_irq    <= 1'b0;
            m_hand   <= 1'b0;
            m_cause  <= 32'h0;
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
            m_rd     <= 1'b0;
            m_rdata  <= 32'h0;
        end else begin
            m_cycles <= m_cycles + 1;
            if (m_acc && bus_we && bus_addr == 16'hBFF8)
                m_mtime <= {m_mtime[63:32], bus_wdata};
            else if (m_acc && bus_we && bus_addr == 16'hBFFC)
                m_mtime <= {bus_wdata, m_mtime[31:0]};
            else if (m_tick)
                m_mtime <= m_mtime + 64'd1;
            if (m_acc && bus_we && bus_addr == 16'h4000) m_cmp <= {m_cmp[63:32], bus_wdata};
            if (m_acc && bus_we && bus_addr == 16'h4004) m_cmp <= {bus_wdata, m_cmp[31:0]};
            if (m_acc && bus_we && bus_addr == 16'h0000) m_msip <= bus_wdata[0];
            m_hist  <= {m_hist[6:0], ext_irq_async};
            m_ready <= m_acc;
            m_rd    <= m_acc && !bus_we;
            m_err   <= m_acc && !m_valid(bus_addr);
            m_rdata <= (m_acc && !bus_we) ? m_read(bus_addr) : 32'h0;
            m_irq   <= m_irq_next;
            m_hand  <= m_hand_next;
            m_cause <= m_irq_next ? m_prio(m_e) : 32'h0;
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("cyc_irq", {63'h0, irq}, {63'h0, m_irq});
            check("cyc_irq_cause", {32'h0, irq_cause}, {32'h0, m_cause});
            check("cyc_pend_bits", {61'h0, pend_bits}, {61'h0, m_pend});
            check("cyc_bus_ready", {63'h0, bus_ready}, {63'h0, m_ready});
            if (m_ready) check("cyc_bus_err", {63'h0, bus_err}, {63'h0, m_err});
            if (m_ready && m_rd) check("cyc_bus_rdata", {32'h0, bus_rdata}, {32'h0, m_rdata});
        end
    end

    // One bus access; called at a negedge with no response outstanding
    task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(negedge clk);
        check("xfer_ready", {63'h0, bus_ready}, 64'h1);
        rdata = bus_rdata;
        err   = bus_err;
        $display("bus %s addr=0x%04h wdata=0x%08h rdata=0x%08h err=%0d",
                 we ? "WR" : "RD", addr, wdata, bus_rdata, bus_err);
        bus_req = 1'b0;
        bus_we  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;
        int          cnt;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = 16'h0; bus_wdata = 32'h0;
        ext_irq_async = 1'b0; mie_bits = 3'b000; mstatus_mie = 1'b0;
        trap_taken = 1'b0; mret_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state and first read
        check("rst_irq", {63'h0, irq}, 64'h0);
        check("rst_cause", {32'h0, irq_cause}, 64'h0);
        check("rst_pend", {61'h0, pend_bits}, 64'h0);
        bus_xfer(1'b0, 16'h4004, 32'h0, rd, er);
        check("rst_cmp_hi", {32'h0, rd}, 64'hFFFF_FFFF);
        check("rst_cmp_hi_err", {63'h0, er}, 64'h0);
        bus_xfer(1'b0, 16'hBFFC, 32'h0, rd, er);
        check("rst_time_hi", {32'h0, rd}, 64'h0);

        // Timer interrupt at mtimecmp = 5
        mstatus_mie = 1'b1;
        bus_xfer(1'b1, 16'h4004, 32'h0, rd, er);
        bus_xfer(1'b1, 16'h4000, 32'h5, rd, er);
        bus_xfer(1'b1, 16'hBFFC, 32'h0, rd, er);
        bus_xfer(1'b1, 16'hBFF8, 32'h0, rd, er);
        mie_bits = 3'b010;
        n = 0;
        while (irq !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mti_irq_rise", {63'h0, irq}, 64'h1);
        check("mti_cause", {32'h0, irq_cause}, 64'h8000_0007);
        check("mti_pend", {61'h0, pend_bits}, 64'h2);
        trap_taken = 1'b1;
        @(negedge clk);
        trap_taken = 1'b0;
        check("handler_irq_low", {63'h0, irq}, 64'h0);
        repeat (5) @(negedge clk);
        check("handler_irq_stays_low", {63'h0, irq}, 64'h0);
        mret_done = 1'b1;
        @(negedge clk);
        mret_done = 1'b0;
        check("mret_idle_gap", {63'h0, irq}, 64'h0);
        @(negedge clk);
        check("mret_rerequest", {63'h0, irq}, 64'h1);

        // Software + external together, then external removed
        mie_bits = 3'b111;
        ext_irq_async = 1'b1;
        bus_xfer(1'b1, 16'h0000, 32'h1, rd, er);
        repeat (3) @(negedge clk);
        check("mei_cause", {32'h0, irq_cause}, 64'h8000_000B);
        ext_irq_async = 1'b0;
        repeat (4) @(negedge clk);
        check("msi_cause", {32'h0, irq_cause}, 64'h8000_0003);

        // Global enable withdrawal and restore
        mstatus_mie = 1'b0;
        @(negedge clk);
        check("mie_drop_irq", {63'h0, irq}, 64'h0);
        check("mie_drop_cause", {32'h0, irq_cause}, 64'h0);
        mstatus_mie = 1'b1;
        @(negedge clk);
        check("mie_restore_irq", {63'h0, irq}, 64'h1);
        check("mie_restore_cause", {32'h0, irq_cause}, 64'h8000_0003);

        // Error responses
        bus_xfer(1'b0, 16'h0008, 32'h0, rd, er);
        check("err_unmapped", {63'h0, er}, 64'h1);
        check("err_unmapped_rdata", {32'h0, rd}, 64'h0);
        bus_xfer(1'b1, 16'h0001, 32'h0, rd, er);
        check("err_misaligned", {63'h0, er}, 64'h1);
        bus_xfer(1'b0, 16'h0000, 32'h0, rd, er);
        check("msip_unchanged", {32'h0, rd}, 64'h1);
        check("msip_read_err", {63'h0, er}, 64'h0);

        // Held request: one access every two cycles
        mie_bits = 3'b000;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 16'h4000;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_ready) cnt++;
        end
        bus_req = 1'b0;
        $display("held request: %0d responses in 6 cycles", cnt);
        check("held_req_rate", 64'(cnt), 64'd3);

        // Write to mtime on a tick edge: the written value wins
        n = 0;
        while ((m_cycles % PRESCALE) != PRESCALE - 1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        bus_xfer(1'b1, 16'hBFF8, 32'h100, rd, er);
        bus_xfer(1'b0, 16'hBFF8, 32'h0, rd, er);
        check("tick_write_wins", {32'h0, rd}, 64'h100);

        // Carry from low to high word
        bus_xfer(1'b1, 16'hBFFC, 32'h0, rd, er);
        bus_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, er);
        n = 0;
        while (m_mtime != 64'h1_0000_0000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("carry_wait", m_mtime, 64'h1_0000_0000);
        bus_xfer(1'b0, 16'hBFFC, 32'h0, rd, er);
        check("carry_hi", {32'h0, rd}, 64'h1);
        bus_xfer(1'b0, 16'hBFF8, 32'h0, rd, er);
        check("carry_lo", {32'h0, rd}, 64'h0);

        // Reset while a response is being presented
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 16'h4004;
        @(negedge clk);
        bus_req = 1'b0;
        check("pre_rst_ready", {63'h0, bus_ready}, 64'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_drops_ready", {63'h0, bus_ready}, 64'h0);
        check("rst_clears_rdata", {32'h0, bus_rdata}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_xfer(1'b0, 16'h4000, 32'h0, rd, er);
        check("post_rst_cmp_lo", {32'h0, rd}, 64'hFFFF_FFFF);
        check("post_rst_irq", {63'h0, irq}, 64'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=no finish required=finish before 200000");
        $fatal(1, "simulation time limit reached");
    end

endmodule
